gecko_data_memory_responder: RTL and testbench
==============================================

# gecko_data_memory_responder

Responder end of the Gecko core's data-memory request stream. It accepts word-addressed load/store requests that were already formatted by the core: store data replicated across byte lanes plus a 4-bit byte mask. It performs masked writes into an internal synchronous RAM and returns full 32-bit read words in request order. The core then applies byte-offset extraction and sign extension. It sits between the Gecko memory stage and the writeback/load path as a tightly coupled data memory.

## Interface
Parameters:
- ADDR_WIDTH, 10: word address width; RAM depth is 2**ADDR_WIDTH words of 32 bits.
- RESP_DEPTH, 2: response buffer capacity. Must be at least 2; this includes the one read in flight in the RAM.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset. Assertion is asynchronous; deassertion is synchronized externally.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_read_enable  in  1  request produces a response word.
- req_write_mask  in  4  byte-lane write enables; bit i writes req_data[8i+7:8i].
- req_addr  in  ADDR_WIDTH  word address (byte address >> 2).
- req_data  in  32  lane-replicated store data.
- resp_valid  out  1  read response present.
- resp_ready  in  1  consumer accepts response.
- resp_data  out  32  raw read word.

## Operation
- Request accept: req_valid && req_ready at a rising edge.
- Write side of an accepted request:
  - For each set bit of req_write_mask, that byte of RAM[req_addr] is updated at the accepting edge.
  - Mask 4'b0000 means no write.
- Read side of an accepted request with req_read_enable=1:
  - RAM[req_addr] is read at the same edge, read-first. A combined read+write returns the pre-write word.
  - The read then becomes in-flight for one cycle.
- Requests with req_read_enable=0 produce no response.
- Requests with read_enable=0 and mask=0 are accepted and ignored.
- Response path:
  - A FIFO of RESP_DEPTH-1 entries holds words not yet taken.
  - When the FIFO is empty, the in-flight RAM output is presented directly on resp_data (bypass).
  - When the FIFO is non-empty, the FIFO head is presented and the in-flight word is pushed to the FIFO tail.
- Push rule at each edge: the in-flight word is pushed if it is present and was not consumed via bypass.
- Pop rule at each edge: the FIFO head is popped on resp_valid && resp_ready when the FIFO is non-empty.
- Push and pop in the same cycle are legal and leave the count unchanged.
- Ordering: responses are strictly in acceptance order.
- Occupancy and backpressure:
  - occupancy = fifo_count + in_flight.
  - req_ready = (occupancy < RESP_DEPTH).
  - req_ready is registered state only and has no combinational path from req_valid or resp_ready.
- RAM contents are not reset and are undefined until written.
- Address arithmetic: req_addr is used as-is. There is no range check, and wrap is implicit in the width.

## Timing
- Reset values: req_ready=1, resp_valid=0, resp_data=0 (gated while not valid), fifo_count=0, in_flight=0.
- Reset asserted mid-operation: in-flight and buffered responses are discarded. RAM writes already committed remain.
- Read latency: a read accepted at edge N gives resp_valid=1 during cycle N+1, with the RAM word captured at edge N.
- Store latency: data written at edge N is visible to a read accepted at edge N+1.
- Throughput: with resp_ready held high, one read is accepted and one response is delivered per cycle indefinitely (occupancy stays at 1).
- Backpressure with resp_ready low and RESP_DEPTH=2:
  - After read 1 is accepted: occupancy 1.
  - Next cycle: read 2 is accepted, read 1 moves to the FIFO, occupancy 2.
  - req_ready then deasserts in the following cycle.
  - resp_valid and resp_data remain stable (read 1's word) until taken.
- Write-only requests also require req_ready, but they do not change occupancy.
- resp_valid must never drop without a handshake. resp_data must never change while resp_valid && !resp_ready.

## Test plan
- Reset, then write 0xDEADBEEF to addr 5 with mask 4'b1111, then read addr 5 -> resp_valid one cycle after the read accept, resp_data=0xDEADBEEF.
- Partial stores:
  - Start with addr 7 = 0x00000000.
  - Store data 0xABABABAB with mask 4'b0100, then data 0x12341234 with mask 4'b0011.
  - Read addr 7 -> 0x00AB1234.
- Combined read+write: addr 3 holds 0x11111111; a request with read_enable=1, mask 4'b1111, data 0x22222222 -> response 0x11111111. A following read of addr 3 -> 0x22222222.
- Backpressure:
  - Hold resp_ready=0 and issue reads to addrs 0, 1, 2 (holding 0xA0, 0xA1, 0xA2).
  - req_ready drops after 2 accepts, and resp_data holds 0xA0.
  - Release resp_ready -> responses 0xA0, 0xA1, 0xA2 in order, and the third read is accepted once occupancy < 2.
- Streaming: 16 back-to-back reads with resp_ready=1 -> req_ready stays 1 throughout, and responses arrive one per cycle with 1-cycle latency and in order.
- Async reset:
  - Assert rst_n=0 mid-cycle with 2 responses pending -> resp_valid drops immediately and req_ready=1.
  - After release, reading the previously written addr 5 -> 0xDEADBEEF.

Source files
------------

// File: rtl/gecko_data_memory_responder.sv
// gecko_data_memory_responder: tightly coupled data RAM with masked stores and in-order read responses
module gecko_data_memory_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int RESP_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_read_enable,
  input  logic [3:0]            req_write_mask,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data
);
  localparam int FD = RESP_DEPTH - 1;
  localparam int PW = FD > 1 ? $clog2(FD) : 1;
  localparam int CW = $clog2(RESP_DEPTH) + 1;
  logic [31:0]     mem [2**ADDR_WIDTH];
  logic [31:0]     fifo [FD];
  logic [31:0]     rd_word;
  logic            in_flight;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   fifo_count, occupancy;
  logic            accept, rd_accept, fifo_empty, fifo_full, bypass_take, push, pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(FD - 1) ? '0 : p + 1'b1;
  endfunction
  // handshakes, occupancy and response selection; all outputs depend on registered state only
  always_comb begin
    occupancy   = fifo_count + CW'(in_flight);
    req_ready   = occupancy < CW'(RESP_DEPTH);
    accept      = req_valid && req_ready;
    rd_accept   = accept && req_read_enable;
    fifo_empty  = fifo_count == '0;
    fifo_full   = fifo_count == CW'(FD);
    resp_valid  = in_flight || !fifo_empty;
    resp_data   = !resp_valid ? 32'h0 : fifo_empty ? rd_word : fifo[rd_ptr];
    bypass_take = fifo_empty && in_flight && resp_ready;
    pop         = !fifo_empty && resp_ready;
    push        = in_flight && !bypass_take && (!fifo_full || pop);
  end
  // RAM: read-first masked write, read word captured into the in-flight register
  always_ff @(posedge clk) begin
    if (accept)
      for (int i = 0; i < 4; i++)
        if (req_write_mask[i]) mem[req_addr][8*i +: 8] <= req_data[8*i +: 8];
    if (rd_accept) rd_word <= mem[req_addr];
  end
  // response FIFO storage; in-flight word lands at the tail when not taken by bypass
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= rd_word;
  end
  // control state; an in-flight word that cannot be pushed stays parked (only when no new read can enter)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight  <= 1'b0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      in_flight  <= rd_accept || (in_flight && !push && !bypass_take);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop) rd_ptr <= inc(rd_ptr);
    end
  end
endmodule

// File: tb/tb_gecko_data_memory_responder.sv
// tb_gecko_data_memory_responder: randomized and directed checks against a queue-based reference model
module tb_gecko_data_memory_responder;
  localparam int AW = 10;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_read_enable = 1'b0;
  logic [3:0]    req_write_mask = 4'h0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_data = 32'h0;
  logic          resp_ready = 1'b0;
  logic          req_ready, resp_valid;
  logic [31:0]   resp_data;
  int            n_checks = 0;
  int            n_fail = 0;
  logic [31:0]   mm [1 << AW];
  logic [31:0]   q [$];

  gecko_data_memory_responder #(.ADDR_WIDTH(AW), .RESP_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_read_enable(req_read_enable), .req_write_mask(req_write_mask),
    .req_addr(req_addr), .req_data(req_data), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one cycle: drive inputs after the falling edge, compare outputs to the model, advance the model
  task automatic step(input logic v, input logic re, input logic [3:0] m, input int a,
                      input logic [31:0] d, input logic rr);
    int sz;
    logic acc;
    req_valid = v; req_read_enable = re; req_write_mask = m;
    req_addr = AW'(a); req_data = d; resp_ready = rr;
    sz = q.size();
    check("req_ready", 32'(req_ready), 32'(sz < 2));
    check("resp_valid", 32'(resp_valid), 32'(sz > 0));
    check("resp_data", resp_data, sz > 0 ? q[0] : 32'h0);
    acc = v && (sz < 2);
    if (sz > 0 && rr) void'(q.pop_front());
    if (acc && re) q.push_back(mm[a]);
    if (acc)
      for (int i = 0; i < 4; i++)
        if (m[i]) mm[a][8*i +: 8] = d[8*i +: 8];
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic rr);
    step(1'b0, 1'b0, 4'h0, 0, 32'h0, rr);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mm[i] = 'x;
    repeat (2) @(negedge clk);
    check("reset_resp_valid", 32'(resp_valid), 32'h0);
    check("reset_req_ready", 32'(req_ready), 32'h1);
    check("reset_resp_data", resp_data, 32'h0);
    rst_n = 1'b1;
    idle(1'b1);
    // full store then read back with one-cycle latency
    step(1'b1, 1'b0, 4'hF, 5, 32'hDEADBEEF, 1'b1);
    step(1'b1, 1'b1, 4'h0, 5, 32'h0, 1'b1);
    check("full_store_const", resp_data, 32'hDEADBEEF);
    idle(1'b1);
    // partial byte-lane stores
    step(1'b1, 1'b0, 4'hF, 7, 32'h00000000, 1'b1);
    step(1'b1, 1'b0, 4'b0100, 7, 32'hABABABAB, 1'b1);
    step(1'b1, 1'b0, 4'b0011, 7, 32'h12341234, 1'b1);
    step(1'b1, 1'b1, 4'h0, 7, 32'h0, 1'b1);
    check("partial_const", resp_data, 32'h00AB1234);
    idle(1'b1);
    // combined read+write returns the pre-write word
    step(1'b1, 1'b0, 4'hF, 3, 32'h11111111, 1'b1);
    step(1'b1, 1'b1, 4'hF, 3, 32'h22222222, 1'b1);
    check("rmw_old_const", resp_data, 32'h11111111);
    step(1'b1, 1'b1, 4'h0, 3, 32'h0, 1'b1);
    check("rmw_new_const", resp_data, 32'h22222222);
    idle(1'b1);
    // backpressure with RESP_DEPTH=2
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'hF, i, 32'hA0 + 32'(i), 1'b1);
    step(1'b1, 1'b1, 4'h0, 0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 4'h0, 1, 32'h0, 1'b0);
    check("bp_ready_low", 32'(req_ready), 32'h0);
    step(1'b1, 1'b1, 4'h0, 2, 32'h0, 1'b0);
    step(1'b1, 1'b1, 4'h0, 2, 32'h0, 1'b0);
    check("bp_hold_const", resp_data, 32'hA0);
    check("bp_hold_valid", 32'(resp_valid), 32'h1);
    step(1'b1, 1'b1, 4'h0, 2, 32'h0, 1'b1);
    check("bp_second_const", resp_data, 32'hA1);
    step(1'b1, 1'b1, 4'h0, 2, 32'h0, 1'b1);
    check("bp_third_const", resp_data, 32'hA2);
    repeat (2) idle(1'b1);
    // streaming: 16 back-to-back reads
    for (int i = 16; i < 32; i++) step(1'b1, 1'b0, 4'hF, i, $urandom, 1'b1);
    for (int i = 16; i < 32; i++) step(1'b1, 1'b1, 4'h0, i, 32'h0, 1'b1);
    repeat (2) idle(1'b1);
    // randomized traffic over addresses 8..31 (all initialised)
    for (int i = 8; i < 16; i++) step(1'b1, 1'b0, 4'hF, i, $urandom, 1'b1);
    for (int n = 0; n < 400; n++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom), int'($urandom_range(8, 31)),
           $urandom, 1'($urandom_range(0, 2) != 0));
    repeat (3) idle(1'b1);
    // asynchronous reset with two responses pending
    step(1'b1, 1'b1, 4'h0, 5, 32'h0, 1'b0);
    step(1'b1, 1'b1, 4'h0, 7, 32'h0, 1'b0);
    check("pre_reset_valid", 32'(resp_valid), 32'h1);
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(resp_valid), 32'h0);
    check("async_rst_ready", 32'(req_ready), 32'h1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1);
    step(1'b1, 1'b1, 4'h0, 5, 32'h0, 1'b1);
    check("post_reset_const", resp_data, 32'hDEADBEEF);
    idle(1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
